// File: rtl/tea_pkg.sv
// Shared constants, round-counter type and FSM encoding for the TEA block encryptor.
package tea_pkg;

    localparam int unsigned ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    typedef logic [5:0] round_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Mod-33 counter: 0..32 then wrap; any out-of-range value also falls back to 0.
    function automatic round_t round_next(input round_t r);
        return (r >= round_t'(ROUNDS)) ? '0 : r + round_t'(1);
    endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA cycle (both half-rounds); sum_next is the already-incremented sum.
module tea_round (
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic [31:0] sum_next,
    input  logic [31:0] k0,
    input  logic [31:0] k1,
    input  logic [31:0] k2,
    input  logic [31:0] k3,
    output logic [31:0] v0_next,
    output logic [31:0] v1_next
);

    // The second half-round mixes in the freshly updated v0, not the registered one.
    assign v0_next = v0 + (((v1 << 4) + k0) ^ (v1 + sum_next) ^ ((v1 >> 5) + k1));
    assign v1_next = v1 + (((v0_next << 4) + k2) ^ (v0_next + sum_next) ^ ((v0_next >> 5) + k3));

endmodule

// File: rtl/tea_encrypt_ctrl.sv
// Iterative TEA encryptor: captures a block on START, runs one TEA cycle per clock,
// presents the ciphertext with a one-cycle DONE pulse.
module tea_encrypt_ctrl #(
    parameter int unsigned ROUNDS = tea_pkg::ROUNDS,
    parameter logic [31:0] DELTA  = tea_pkg::DELTA
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [127:0] KEY,
    input  logic [63:0]  V_IN,
    output logic         READY,
    output logic         BUSY,
    output logic         DONE,
    output logic [63:0]  V_OUT,
    output logic [5:0]   ROUND
);
    import tea_pkg::*;

    localparam round_t LAST_ROUND = round_t'(ROUNDS - 1);
    localparam round_t MAX_ROUND  = round_t'(ROUNDS);

    state_t       state_q, state_d;
    round_t       round_q, round_d;
    logic [31:0]  sum_q, sum_d;
    logic [31:0]  v0_q, v0_d;
    logic [31:0]  v1_q, v1_d;
    logic [127:0] key_q, key_d;
    logic [63:0]  vout_q, vout_d;

    logic [31:0]  sum_nx, v0_nx, v1_nx;

    assign sum_nx = sum_q + DELTA;

    tea_round u_round (
        .v0       (v0_q),
        .v1       (v1_q),
        .sum_next (sum_nx),
        .k0       (key_q[127:96]),
        .k1       (key_q[95:64]),
        .k2       (key_q[63:32]),
        .k3       (key_q[31:0]),
        .v0_next  (v0_nx),
        .v1_next  (v1_nx)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        round_d = round_q;
        sum_d   = sum_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        key_d   = key_q;
        vout_d  = vout_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    v0_d    = V_IN[63:32];
                    v1_d    = V_IN[31:0];
                    key_d   = KEY;
                    sum_d   = '0;
                    round_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_nx;
                v0_d    = v0_nx;
                v1_d    = v1_nx;
                round_d = round_next(round_q);
                if (round_q == LAST_ROUND) begin
                    vout_d  = {v0_nx, v1_nx};
                    state_d = FIN;
                end
            end
            FIN: begin
                round_d = round_next(round_q);
                state_d = IDLE;
            end
            default: begin
                round_d = '0;
                state_d = IDLE;
            end
        endcase

        // An illegal counter value overrides everything and recovers to a clean IDLE.
        if (round_q > MAX_ROUND) begin
            round_d = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            round_q <= '0;
            sum_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            key_q   <= '0;
            vout_q  <= '0;
        end else begin
            // NOTE: non-blocking updates keep all registers sampling the same pre-edge values.
            state_q <= state_d;
            round_q <= round_d;
            sum_q   <= sum_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            key_q   <= key_d;
            vout_q  <= vout_d;
        end
    end

    assign READY = (state_q == IDLE);
    assign BUSY  = (state_q == RUN);
    assign DONE  = (state_q == FIN);
    assign V_OUT = vout_q;
    assign ROUND = round_q;

endmodule

// File: tb/tb_tea_encrypt_ctrl.sv
// Directed bench for tea_encrypt_ctrl with a result scoreboard and a TEA reference model.
module tb_tea_encrypt_ctrl;

    logic         CLK   = 1'b0;
    logic         RST   = 1'b0;
    logic         START = 1'b0;
    logic [127:0] KEY   = '0;
    logic [63:0]  V_IN  = '0;
    logic         READY;
    logic         BUSY;
    logic         DONE;
    logic [63:0]  V_OUT;
    logic [5:0]   ROUND;

    int n_cmp    = 0;
    int n_mis    = 0;
    int done_cnt = 0;

    logic [63:0] sb [$];

    tea_encrypt_ctrl #(
        .ROUNDS (32),
        .DELTA  (32'h9E3779B9)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .KEY   (KEY),
        .V_IN  (V_IN),
        .READY (READY),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .V_OUT (V_OUT),
        .ROUND (ROUND)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] v);
        logic [31:0] a, b, s;
        a = v[63:32];
        b = v[31:0];
        s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            s = s + 32'h9E3779B9;
            a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
            b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] exp_round(input int p);
        return (p <= 32) ? 64'(p) : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_inputs();
        KEY  = {$urandom(), $urandom(), $urandom(), $urandom()};
        V_IN = {$urandom(), $urandom()};
    endtask

    // One-edge START from IDLE; the expected ciphertext comes from the model on the driven values.
    task automatic start_block();
        START = 1'b1;
        sb.push_back(tea_enc(KEY, V_IN));
        tick();
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("round_after_start", ROUND, 0);
    endtask

    task automatic wait_done(input int max_cycles, input bit scramble);
        for (int i = 0; i < max_cycles; i++) begin
            if (scramble) rand_inputs();
            tick();
            if (DONE) break;
        end
        check("done_within_bound", DONE, 1);
    endtask

    // Scoreboard side: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            done_cnt++;
            check("sb_has_entry", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) check("v_out", V_OUT, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int p;
        logic [63:0] r1, r2;

        // Reset values, asynchronously, before any clock edge
        #1 RST = 1'b1;
        #1;
        check("rst_ready", READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_round", ROUND, 0);
        check("rst_vout", V_OUT, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Known vector, exact latency
        KEY   = '0;
        V_IN  = '0;
        START = 1'b1;
        sb.push_back(64'h41EA3A0A_94BAA940);
        tick();
        START = 1'b0;
        check("a_busy", BUSY, 1);
        check("a_ready", READY, 0);
        check("a_round0", ROUND, 0);
        repeat (31) tick();
        check("a_round31", ROUND, 31);
        check("a_done_early", DONE, 0);
        check("a_busy31", BUSY, 1);
        tick();
        check("a_done", DONE, 1);
        check("a_round32", ROUND, 32);
        check("a_ready_fin", READY, 0);
        check("a_busy_fin", BUSY, 0);
        tick();
        check("a_ready_idle", READY, 1);
        check("a_done_clear", DONE, 0);
        check("a_round_wrap", ROUND, 0);
        check("a_done_count", 64'(done_cnt), 1);

        // START pulses mid-run (ROUND=10) and during FIN must be ignored
        rand_inputs();
        d0 = done_cnt;
        start_block();
        for (int i = 1; i <= 31; i++) begin
            if (i == 11) begin
                check("b_round10", ROUND, 10);
                START = 1'b1;
                rand_inputs();
            end else begin
                START = 1'b0;
            end
            tick();
            check("b_ready_low", READY, 0);
        end
        tick();
        check("b_done", DONE, 1);
        check("b_ready_fin", READY, 0);
        START = 1'b1;
        rand_inputs();
        tick();
        START = 1'b0;
        check("b_ready_idle", READY, 1);
        check("b_round_wrap", ROUND, 0);
        tick();
        check("b_not_queued", BUSY, 0);
        check("b_single_done", 64'(done_cnt - d0), 1);

        // Asynchronous reset at ROUND=17 aborts the block
        rand_inputs();
        start_block();
        repeat (17) tick();
        check("c_round17", ROUND, 17);
        #2 RST = 1'b1;
        void'(sb.pop_back());
        d0 = done_cnt;
        #1;
        check("c_ready", READY, 1);
        check("c_busy", BUSY, 0);
        check("c_round", ROUND, 0);
        check("c_vout", V_OUT, 0);
        check("c_done", DONE, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        rand_inputs();
        start_block();
        check("c_no_done_abort", 64'(done_cnt - d0), 0);
        wait_done(40, 1'b1);
        tick();
        check("c_ready_after", READY, 1);
        check("c_fresh_done", 64'(done_cnt - d0), 1);

        // START held high: back-to-back blocks every 34 cycles, inputs scrambled every cycle
        START = 1'b1;
        for (int e = 0; e < 100; e++) begin
            p = e % 34;
            rand_inputs();
            if (p == 0) sb.push_back(tea_enc(KEY, V_IN));
            tick();
            check("d_round_trace", ROUND, exp_round(p));
            check("d_done_trace", DONE, 64'(p == 32));
        end
        START = 1'b0;
        tick();
        check("d_last_done", DONE, 1);
        check("d_last_round", ROUND, 32);
        tick();
        check("d_idle", READY, 1);
        check("d_sb_drained", 64'(sb.size()), 0);

        // Two consecutive blocks: V_OUT holds the first result through the second run
        rand_inputs();
        r1 = tea_enc(KEY, V_IN);
        start_block();
        wait_done(40, 1'b1);
        check("e_first", V_OUT, r1);
        tick();
        rand_inputs();
        r2 = tea_enc(KEY, V_IN);
        start_block();
        check("e_hold_start", V_OUT, r1);
        for (int i = 0; i < 31; i++) begin
            rand_inputs();
            tick();
            check("e_hold_run", V_OUT, r1);
        end
        tick();
        check("e_second_done", DONE, 1);
        check("e_second", V_OUT, r2);
        repeat (3) begin
            tick();
            check("e_hold_idle", V_OUT, r2);
        end

        check("final_sb_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tea_encrypt_ctrl.md
TEA_ENCRYPT_CTRL -- requirements
Module: tea_encrypt_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, number of TEA cycles per block; only 32 is supported.
REQ-002 SHALL have parameter DELTA, default 32'h9E3779B9, per-cycle sum increment.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port START  input  1  request to encrypt V_IN with KEY; sampled only when READY=1.
REQ-006 SHALL have port KEY  input  128  key; k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-007 SHALL have port V_IN  input  64  plaintext; v0=[63:32], v1=[31:0].
REQ-008 SHALL have port READY  output  1  high only in IDLE.
REQ-009 SHALL have port BUSY  output  1  high only in RUN.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse when V_OUT becomes valid.
REQ-011 SHALL have port V_OUT  output  64  ciphertext, same packing as V_IN.
REQ-012 SHALL have port ROUND  output  6  current round counter value, 0..32.

Function
REQ-013 SHALL implement the states IDLE, RUN and FIN.
REQ-014 IDLE with START=1 SHALL, on the next edge, capture V_IN and KEY into internal registers, clear sum to 0, set ROUND=0 and enter RUN.
REQ-015 IDLE with START=0 SHALL hold all registers.
REQ-016 Each RUN edge SHALL perform one full TEA cycle: sum+=DELTA; v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1); v1+=((v0'<<4)+k2)^(v0'+sum)^((v0'>>5)+k3), where v0' is the updated v0.
REQ-017 All TEA arithmetic SHALL be modulo 2^32 with logical shifts.
REQ-018 ROUND SHALL advance as a 6-bit mod-33 counter (0->1->...->32->0), incrementing once per RUN edge.
REQ-019 The RUN edge on which ROUND goes from 31 to 32 SHALL apply the final cycle, latch the result into V_OUT and enter FIN.
REQ-020 FIN SHALL assert DONE for exactly one cycle, then on the next edge enter IDLE with ROUND wrapping 32->0.
REQ-021 Latency SHALL be fixed: START sampled at edge k produces DONE=1 and a valid V_OUT after edge k+32, and READY=1 after edge k+33.
REQ-022 START while in RUN or FIN SHALL be ignored; it is neither queued nor allowed to alter KEY, V_IN or the running state.
REQ-023 V_OUT SHALL hold its value from FIN until the next completion; it SHALL NOT change during a subsequent RUN.
REQ-024 Changes on KEY or V_IN after capture SHALL NOT affect the block in progress.
REQ-025 ROUND values 33..63 SHALL be unreachable; if forced into one, the counter SHALL return to 0 and the FSM to IDLE on the next edge.

Reset
REQ-026 RST=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, ROUND=0, sum=0, internal v0/v1/key=0, V_OUT=0, DONE=0, BUSY=0 and READY=1.
REQ-027 RST asserted mid-RUN SHALL abort the block; no DONE pulse SHALL occur for it and V_OUT SHALL read 0.
REQ-028 After RST deasserts, the first START SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-029 Package tea_pkg SHALL hold DELTA, ROUNDS, the 6-bit round type and the state encoding (IDLE, RUN, FIN).
REQ-030 The combinational TEA cycle SHALL be a sub-module tea_round with inputs v0, v1, sum_next and k0..k3 and outputs v0_next and v1_next.
REQ-031 The mod-33 next-count logic SHALL be a separate combinational function of ROUND; the FSM and all registers SHALL reside in tea_encrypt_ctrl.

Verification
REQ-032 KEY=0 and V_IN=0 with a 1-cycle START -> after 32 edges, DONE pulses once and V_OUT=64'h41EA3A0A_94BAA940.
REQ-033 START pulsed while BUSY=1 in a mid-block cycle (e.g. ROUND=10), and again during FIN -> the result is identical to an undisturbed run, there is exactly one DONE pulse, and READY=0 throughout.
REQ-034 RST asserted while ROUND=17 -> asynchronously READY=1, BUSY=0, ROUND=0 and V_OUT=0, with no DONE pulse; a fresh START then yields the correct ciphertext.
REQ-035 START held high continuously for 100 cycles -> blocks complete back-to-back every 34 cycles, with ROUND tracing 0..32,0 each time.
REQ-036 KEY and V_IN randomized every cycle after capture -> V_OUT matches a reference model computed on the captured values only.
REQ-037 Two consecutive blocks -> V_OUT holds the first result unchanged through the second RUN and updates only on the second DONE.
